digit_sprite_reader: RTL

//  Initiator side of the 20x20 digit-sprite ROM interface. Takes the VGA scan position and a

---
 rtl/digit_sprite_reader.sv | 115 +++++++++++
 1 files changed

// File: rtl/digit_sprite_reader.sv
// ---------------------------------------------------------------------------
// digit_sprite_reader
//   Initiator side of the digit-sprite ROM interface. From the VGA scan
//   position and a per-frame sprite origin it issues a registered pixel
//   address to a 1-cycle-latency block ROM. It returns the ROM colour and an
//   opaque/hit flag aligned with hsync/vsync, three cycles after the scan
//   position is presented. Use one instance per on-screen digit.
//
// Ports
//   i_clk2         pixel clock, shared with the ROM
//   i_rst_n        asynchronous active-low reset
//   i_pix_x/y      current scan column/row
//   i_pix_active   1 = visible region
//   i_hsync/vsync  sync from the timing generator
//   i_frame_start  one-cycle pulse at start of frame; latches the origin
//   i_sprite_x/y   requested sprite origin (top-left)
//   i_enable       0 = sprite hidden
//   o_rom_addr     registered ROM address
//   i_rom_data     ROM data, valid one cycle after o_rom_addr is sampled
//   o_pixel        sprite colour, 0 when no hit
//   o_hit          1 = opaque sprite pixel at this position
//   o_hsync/vsync  sync inputs delayed by 3 cycles
// ---------------------------------------------------------------------------
module digit_sprite_reader #(
  parameter int unsigned SPRITE_W    = 20,
  parameter int unsigned SPRITE_H    = 20,
  parameter int unsigned ADDR_W      = 10,
  parameter logic [7:0]  TRANSPARENT = 8'h00
) (
  input  logic              i_clk2,
  input  logic              i_rst_n,
  input  logic [9:0]        i_pix_x,
  input  logic [9:0]        i_pix_y,
  input  logic              i_pix_active,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_frame_start,
  input  logic [9:0]        i_sprite_x,
  input  logic [9:0]        i_sprite_y,
  input  logic              i_enable,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [7:0]        i_rom_data,
  output logic [7:0]        o_pixel,
  output logic              o_hit,
  output logic              o_hsync,
  output logic              o_vsync
);

  logic [9:0]        r_org_x;
  logic [9:0]        r_org_y;
  logic              r_org_en;
  logic              r_in_s1;
  logic              r_in_s2;
  logic [2:0]        r_hs_dly;
  logic [2:0]        r_vs_dly;

  logic [10:0]       w_col;
  logic [10:0]       w_row;
  logic              w_inside;
  logic [ADDR_W-1:0] w_addr;
  logic              w_hit_next;

  // Origin is only updated on frame_start so a moving digit never tears.
  // A pixel presented in the same cycle as frame_start still sees the old
  // origin because the latch lands on the same edge that samples the pixel.
  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_org_x  <= '0;
      r_org_y  <= '0;
      r_org_en <= 1'b0;
    end else if (i_frame_start) begin
      r_org_x  <= i_sprite_x;
      r_org_y  <= i_sprite_y;
      r_org_en <= i_enable;
    end
  end

  // Bit 10 is the borrow: a scan position left of/above the origin must not
  // alias into the sprite (e.g. origin 1023 with x = 0..18).
  assign w_col = {1'b0, i_pix_x} - {1'b0, r_org_x};
  assign w_row = {1'b0, i_pix_y} - {1'b0, r_org_y};

  assign w_inside = r_org_en && i_pix_active && !w_col[10] && !w_row[10] &&
                    (w_col < 11'(SPRITE_W)) && (w_row < 11'(SPRITE_H));

  // Only evaluated when inside, so row < SPRITE_H and col < SPRITE_W and the
  // result stays within SPRITE_W*SPRITE_H-1.
  assign w_addr = ADDR_W'(w_row) * ADDR_W'(SPRITE_W) + ADDR_W'(w_col);

  assign w_hit_next = r_in_s2 && (i_rom_data != TRANSPARENT);

  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rom_addr <= '0;
      r_in_s1    <= 1'b0;
      r_in_s2    <= 1'b0;
      o_hit      <= 1'b0;
      o_pixel    <= 8'h00;
      r_hs_dly   <= 3'b000;
      r_vs_dly   <= 3'b000;
    end else begin
      o_rom_addr <= w_inside ? w_addr : '0;
      r_in_s1    <= w_inside;
      r_in_s2    <= r_in_s1;
      o_hit      <= w_hit_next;
      o_pixel    <= w_hit_next ? i_rom_data : 8'h00;
      r_hs_dly   <= {r_hs_dly[1:0], i_hsync};
      r_vs_dly   <= {r_vs_dly[1:0], i_vsync};
    end
  end

  assign o_hsync = r_hs_dly[2];
  assign o_vsync = r_vs_dly[2];

endmodule
